timer_done_collector: RTL and testbench

Downstream consumer of the `timer` instances' `done` outputs. Watches NUM_SRC done lines for rising edges and keeps a sticky per-source status. Queues source IDs in arrival order and presents them on a valid/ready event port, with first-finisher and all-finished indications. Replaces the testbench-level `wait`/`fork` race with synthesizable logic that the control path can poll or drain.

---
 rtl/timer_pkg.sv | 9 +
 rtl/id_fifo.sv | 53 +++++
 rtl/timer_done_collector.sv | 101 ++++++++++
 tb/tb_timer_done_collector.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared definitions for the timer family: source-count ceiling and a source ID type
// wide enough for any legal configuration.
package timer_pkg;

    localparam int MAX_SRC = 16;

    typedef logic [$clog2(MAX_SRC)-1:0] id_t;

endpackage

// File: rtl/id_fifo.sv
// Show-ahead FIFO of source IDs; push and pop may coincide even when full,
// since the pop frees the slot the push reuses.
module id_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/timer_done_collector.sv
// Collects rising edges of timer done lines into sticky status and an ordered
// event queue, with first-finisher, all-finished and lost-edge indications.
module timer_done_collector
    import timer_pkg::*;
#(
    parameter int NUM_SRC = 3,
    parameter int DEPTH   = 4,
    parameter int ID_W    = $clog2(NUM_SRC)
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               clear,
    input  logic [NUM_SRC-1:0] done,
    output logic               evt_valid,
    output logic [ID_W-1:0]    evt_id,
    input  logic               evt_ready,
    output logic [NUM_SRC-1:0] status,
    output logic               first_valid,
    output logic [ID_W-1:0]    first_id,
    output logic               all_done,
    output logic               overflow
);

    logic [NUM_SRC-1:0] done_q;
    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] pending;
    logic [NUM_SRC-1:0] grant;
    logic [ID_W-1:0]    push_id;
    logic               push;
    logic               pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic               can_push;

    assign rise      = done & ~done_q;
    assign evt_valid = !fifo_empty;
    assign pop       = evt_valid && evt_ready;
    assign can_push  = !fifo_full || pop;
    assign push      = |grant;
    assign all_done  = &status;

    // Descending scan so the lowest-index pending source is the one left granted.
    always_comb begin
        grant   = '0;
        push_id = '0;
        if (can_push) begin
            for (int i = NUM_SRC - 1; i >= 0; i--) begin
                if (pending[i]) begin
                    grant    = '0;
                    grant[i] = 1'b1;
                    push_id  = ID_W'(i);
                end
            end
        end
    end

    // done_q tracks done even on clear so lines already high do not re-fire afterwards.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            done_q      <= '0;
            pending     <= '0;
            status      <= '0;
            overflow    <= 1'b0;
            first_valid <= 1'b0;
            first_id    <= '0;
        end else begin
            done_q <= done;
            if (clear) begin
                pending     <= '0;
                status      <= '0;
                overflow    <= 1'b0;
                first_valid <= 1'b0;
                first_id    <= '0;
            end else begin
                pending  <= (pending | rise) & ~grant;
                status   <= status | rise;
                overflow <= overflow | (|(rise & pending & ~grant));
                if (push && !first_valid) begin
                    first_valid <= 1'b1;
                    first_id    <= push_id;
                end
            end
        end
    end

    id_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ID_W)
    ) u_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .clear     (clear),
        .push      (push),
        .push_data (push_id),
        .pop       (pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (evt_id)
    );

endmodule

// File: tb/tb_timer_done_collector.sv
// Directed bench for timer_done_collector: stimulus queues expected event IDs,
// a monitor pops and compares them on every accepted event.
module tb_timer_done_collector;

    localparam int NUM_SRC = 6;
    localparam int DEPTH   = 4;
    localparam int ID_W    = $clog2(NUM_SRC);

    logic               clk = 1'b0;
    logic               rstn;
    logic               clear;
    logic [NUM_SRC-1:0] done;
    logic               evt_valid;
    logic [ID_W-1:0]    evt_id;
    logic               evt_ready;
    logic [NUM_SRC-1:0] status;
    logic               first_valid;
    logic [ID_W-1:0]    first_id;
    logic               all_done;
    logic               overflow;

    int checks = 0;
    int errors = 0;
    int exp_q[$];

    always #5 clk = ~clk;

    timer_done_collector #(
        .NUM_SRC (NUM_SRC),
        .DEPTH   (DEPTH)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .clear       (clear),
        .done        (done),
        .evt_valid   (evt_valid),
        .evt_id      (evt_id),
        .evt_ready   (evt_ready),
        .status      (status),
        .first_valid (first_valid),
        .first_id    (first_id),
        .all_done    (all_done),
        .overflow    (overflow)
    );

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic apply_stimulus(input logic [NUM_SRC-1:0] d, input logic rdy);
        done      = d;
        evt_ready = rdy;
    endtask

    // Every accepted event must match the oldest expected ID.
    always @(negedge clk) begin
        if (rstn && evt_valid && evt_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_event: got id %0d, expected no event at %0t", evt_id, $time);
            end else begin
                check_output("evt_order", 32'(evt_id), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        rstn  = 1'b0;
        clear = 1'b0;
        apply_stimulus('0, 1'b1);
        #23;
        check_output("rst_evt_valid", 32'(evt_valid), 0);
        check_output("rst_status", 32'(status), 0);
        check_output("rst_first_valid", 32'(first_valid), 0);
        check_output("rst_all_done", 32'(all_done), 0);
        check_output("rst_overflow", 32'(overflow), 0);
        @(negedge clk);
        rstn = 1'b1;
        tick(2);

        // Staggered finishers, consumer always ready.
        apply_stimulus(6'b000001, 1'b1);
        exp_q.push_back(0);
        tick();
        check_output("lat_status", 32'(status), 32'h01);
        check_output("lat_valid_k", 32'(evt_valid), 0);
        tick();
        check_output("lat_valid_k1", 32'(evt_valid), 1);
        check_output("lat_id_k1", 32'(evt_id), 0);
        check_output("first_valid", 32'(first_valid), 1);
        check_output("first_id0", 32'(first_id), 0);
        tick(48);
        apply_stimulus(6'b000011, 1'b1);
        exp_q.push_back(1);
        tick(50);
        apply_stimulus(6'b000111, 1'b1);
        exp_q.push_back(2);
        tick();
        check_output("all_done_partial", 32'(all_done), 0);
        tick(5);
        apply_stimulus(6'b111111, 1'b1);
        exp_q.push_back(3);
        exp_q.push_back(4);
        exp_q.push_back(5);
        tick();
        check_output("all_done_full", 32'(all_done), 1);
        tick(6);
        check_output("ovf_clean", 32'(overflow), 0);
        check_output("first_id_held", 32'(first_id), 0);

        // Clear with lines held high: nothing re-fires.
        clear = 1'b1;
        tick();
        clear = 1'b0;
        tick(4);
        check_output("held_no_refire", 32'(evt_valid), 0);
        check_output("held_status", 32'(status), 0);
        apply_stimulus('0, 1'b1);
        tick(2);

        // Simultaneous rises with consumer stalled, then FIFO full and lost edge.
        apply_stimulus(6'b000111, 1'b0);
        tick();
        check_output("sim_status", 32'(status), 32'h07);
        check_output("sim_valid_k", 32'(evt_valid), 0);
        tick(3);
        check_output("sim_head0", 32'(evt_id), 0);
        exp_q.push_back(0);
        exp_q.push_back(1);
        exp_q.push_back(2);
        evt_ready = 1'b1;
        tick();
        evt_ready = 1'b0;
        check_output("sim_head1", 32'(evt_id), 1);
        apply_stimulus(6'b111111, 1'b0);
        exp_q.push_back(3);
        exp_q.push_back(4);
        exp_q.push_back(5);
        tick(5);
        check_output("full_no_ovf", 32'(overflow), 0);
        check_output("full_head", 32'(evt_id), 1);
        apply_stimulus(6'b011111, 1'b0);
        tick();
        apply_stimulus(6'b111111, 1'b0);
        tick();
        check_output("ovf_set", 32'(overflow), 1);
        evt_ready = 1'b1;
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick();
        check_output("drain_done", 32'(exp_q.size()), 0);
        tick(3);
        check_output("drain_empty", 32'(evt_valid), 0);
        check_output("ovf_sticky", 32'(overflow), 1);

        // Clear while an event is queued and done[2] is held.
        apply_stimulus('0, 1'b0);
        tick();
        apply_stimulus(6'b000100, 1'b0);
        tick(2);
        check_output("pre_clear_valid", 32'(evt_valid), 1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check_output("clr_valid", 32'(evt_valid), 0);
        check_output("clr_status", 32'(status), 0);
        check_output("clr_first_valid", 32'(first_valid), 0);
        check_output("clr_overflow", 32'(overflow), 0);
        evt_ready = 1'b1;
        tick(5);
        check_output("clr_no_refire", 32'(evt_valid), 0);
        apply_stimulus('0, 1'b1);
        tick();
        apply_stimulus(6'b000100, 1'b1);
        exp_q.push_back(2);
        tick(4);
        check_output("clr_first_id", 32'(first_id), 2);

        // Asynchronous reset in the middle of a cycle with events queued.
        apply_stimulus('0, 1'b0);
        tick();
        apply_stimulus(6'b000011, 1'b0);
        tick(3);
        #2;
        rstn = 1'b0;
        #1;
        check_output("arst_valid", 32'(evt_valid), 0);
        check_output("arst_status", 32'(status), 0);
        check_output("arst_first_valid", 32'(first_valid), 0);
        check_output("arst_evt_id", 32'(evt_id), 0);
        apply_stimulus('0, 1'b1);
        @(negedge clk);
        rstn = 1'b1;
        tick(10);
        check_output("post_rst_quiet", 32'(evt_valid), 0);
        check_output("final_queue", 32'(exp_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
